// File: rtl/calculator_pkg.sv
// Shared widths and controller state encoding for the calculator
// memory sequencer.
package calculator_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    // One extra bit so pointer compares never wrap.
    typedef logic [ADDR_W:0] wide_addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_ADD,
        S_WRITE,
        S_END
    } ctrl_state_t;

endpackage

// File: rtl/adder32.sv
// Operand adder for the calculator datapath.
// The sum wraps and the carry out is dropped.
module adder32
    import calculator_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/calc_controller.sv
// Streams operand pairs out of SRAM, adds each pair and
// writes the sum back, owning the memory while busy.
module calc_controller
    import calculator_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] read_start_i,
    input  logic [ADDR_W-1:0] read_end_i,
    input  logic [ADDR_W-1:0] write_start_i,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o
);

    ctrl_state_t       state;
    ctrl_state_t       state_n;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] end_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] sum;
    logic              start_ok;
    logic              more;

    adder32 u_add (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (sum)
    );

    assign start_ok = wide_addr_t'(read_start_i) + wide_addr_t'(1)
                      <= wide_addr_t'(read_end_i);
    assign more = wide_addr_t'(rd_ptr) + wide_addr_t'(3)
                  <= wide_addr_t'(end_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            end_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rd_ptr <= read_start_i;
                        end_q  <= read_end_i;
                        wr_ptr <= write_start_i;
                    end
                end
                S_READ_B: op_a_q <= mem_rdata_i;
                S_ADD:    op_b_q <= mem_rdata_i;
                S_WRITE: begin
                    rd_ptr <= rd_ptr + ADDR_W'(2);
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        busy_o      = (state != S_IDLE);
        done_o      = (state == S_END);
        unique case (state)
            S_IDLE: begin
                if (start_i)
                    state_n = start_ok ? S_READ_A : S_END;
            end
            S_READ_A: begin
                mem_en_o   = 1'b1;
                mem_addr_o = rd_ptr;
                state_n    = S_READ_B;
            end
            S_READ_B: begin
                mem_en_o   = 1'b1;
                mem_addr_o = rd_ptr + ADDR_W'(1);
                state_n    = S_ADD;
            end
            S_ADD: state_n = S_WRITE;
            S_WRITE: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = wr_ptr;
                mem_wdata_o = sum;
                state_n     = more ? S_READ_A : S_END;
            end
            S_END:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller with a job-level model
// of expected writes, read window, busy span and done timing.
module tb_calc_controller;
    import calculator_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  read_start = '0;
    logic [7:0]  read_end = '0;
    logic [7:0]  write_start = '0;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        done;

    calc_controller dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .read_start_i  (read_start),
        .read_end_i    (read_end),
        .write_start_i (write_start),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM with a preload port so only one process writes it.
    logic [31:0] sram [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)
            sram[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we)
                sram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= sram[mem_addr];
        end
    end

    logic [31:0] ref_mem [256];
    logic [7:0]  exp_addr [8];
    logic [31:0] exp_data [8];
    int job_s = -10;
    int job_end = -10;
    int job_id = 0;
    int exp_n = 0;
    int lo = 0;
    int hi = -1;
    bit aborted = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int done_at = -1;
    int obs_writes = 0;
    int obs_en = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    initial begin
        int  seen;
        int  idx;
        bit  exp_busy;
        seen = 0;
        idx = 0;
        forever begin
            @(negedge clk);
            if (job_id != seen) begin
                seen = job_id;
                idx = 0;
                obs_writes = 0;
                obs_en = 0;
                done_at = -1;
            end
            exp_busy = (cyc > job_s) && (cyc <= job_end);
            chk("busy", busy, exp_busy);
            chk("done", done, exp_busy && cyc == job_end && !aborted);
            if (done)
                done_at = cyc;
            if (mem_en)
                obs_en++;
            if (mem_en && mem_we) begin
                chk("wr_expected", idx < exp_n, 1);
                if (idx < exp_n) begin
                    chk("wr_addr", mem_addr, exp_addr[idx]);
                    chk("wr_data", mem_wdata, exp_data[idx]);
                    idx++;
                    obs_writes++;
                end
            end else if (mem_en) begin
                chk("rd_range",
                    int'(mem_addr) >= lo && int'(mem_addr) <= hi, 1);
            end else begin
                chk("idle_bus", {mem_we, mem_addr, mem_wdata}, 0);
            end
            if (cyc == job_end && !aborted)
                chk("write_total", idx, exp_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_addr = 8'(a);
        pl_data = d;
        ref_mem[a] = d;
        tick();
    endtask

    task automatic start_job(input int rs, input int re, input int ws,
                             output int c);
        int n;
        c = cyc;
        n = (re >= rs) ? (re - rs + 1) / 2 : 0;
        for (int i = 0; i < n; i++) begin
            exp_addr[i] = 8'(ws + i);
            exp_data[i] = ref_mem[rs + 2 * i] + ref_mem[rs + 2 * i + 1];
        end
        for (int i = 0; i < n; i++)
            ref_mem[exp_addr[i]] = exp_data[i];
        lo = rs;
        hi = rs + 2 * n - 1;
        exp_n = n;
        job_s = c;
        job_end = c + 4 * n + 1;
        aborted = 1'b0;
        job_id++;
        read_start = 8'(rs);
        read_end = 8'(re);
        write_start = 8'(ws);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_job();
        while (cyc <= job_end + 1)
            tick();
    endtask

    initial begin
        int c;
        rst = 1'b1;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        preload(0, 32'd5);
        preload(1, 32'd7);
        preload(2, 32'd1);
        preload(3, 32'd2);
        preload(4, 32'd3);
        preload(5, 32'd4);
        preload(6, 32'hFFFF_FFFF);
        preload(7, 32'd1);
        preload(8, 32'd10);
        preload(9, 32'd20);
        preload(10, 32'd30);
        preload(11, 32'd40);
        preload(8'h40, 32'd100);
        preload(8'h41, 32'd200);
        preload(8'h42, 32'h8000_0000);
        preload(8'h43, 32'h8000_0001);
        pl_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        start_job(0, 1, 8'h10, c);
        finish_job();
        chk("t1_latency", done_at - c, 5);
        chk("t1_mem", sram[8'h10], 32'h0000_000C);
        chk("t1_writes", obs_writes, 1);

        start_job(2, 7, 8'h20, c);
        finish_job();
        chk("t2_latency", done_at - c, 13);
        chk("t2_mem0", sram[8'h20], 32'd3);
        chk("t2_mem1", sram[8'h21], 32'd7);
        chk("t2_mem2", sram[8'h22], 32'd0);
        chk("t2_writes", obs_writes, 3);

        start_job(4, 4, 8'h70, c);
        finish_job();
        chk("t3a_latency", done_at - c, 1);
        chk("t3a_en", obs_en, 0);
        start_job(5, 3, 8'h70, c);
        finish_job();
        chk("t3b_latency", done_at - c, 1);
        chk("t3b_en", obs_en, 0);

        start_job(0, 4, 8'h30, c);
        finish_job();
        chk("t4_writes", obs_writes, 2);
        chk("t4_mem0", sram[8'h30], 32'd12);
        chk("t4_mem1", sram[8'h31], 32'd3);

        start_job(8, 11, 8'h50, c);
        tick();
        read_start = 8'd0;
        read_end = 8'd7;
        write_start = 8'h60;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_job();
        chk("t5_latency", done_at - c, 9);
        chk("t5_writes", obs_writes, 2);
        chk("t5_mem0", sram[8'h50], 32'd30);
        chk("t5_mem1", sram[8'h51], 32'd70);

        start_job(8, 11, 8'h58, c);
        tick();
        tick();
        rst = 1'b1;
        aborted = 1'b1;
        job_end = cyc;
        exp_n = 0;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("t5_rst_writes", obs_writes, 0);
        chk("t5_rst_done", done_at, -1);

        start_job(8'h40, 8'h43, 8'hFF, c);
        finish_job();
        chk("t6_latency", done_at - c, 9);
        chk("t6_writes", obs_writes, 2);
        chk("t6_mem_ff", sram[8'hFF], 32'h0000_012C);
        chk("t6_mem_00", sram[8'h00], 32'd1);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
